// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//   IF-stage program counter, next-PC selection and F/D pipeline register for
//   the 5-stage MIPS core. Delayed-branch semantics: the instruction fetched
//   while a branch/jump sits in D (the delay slot) always enters D. The only
//   exception is a not-taken branch-likely, which nullifies the slot.
//
//   Optional feature macro: BRANCH_LIKELY_EN
//     defined   -> npc_op 3'b100 is branch-likely (nullifies the slot when not taken)
//     undefined -> npc_op 3'b100 behaves as sequential; no nullify logic exists
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset
//   stall      in   1  hazard stall; holds PC and the F/D register
//   instr_f    in  32  IM read data at pc_f
//   pc_f       out 32  current fetch address
//   cmp_out    in   1  D-stage comparator result (1 = condition true)
//   npc_op     in   3  next-PC select: 000 seq, 001 br, 010 j/jal, 011 jr, 100 br-likely
//   imm16_d    in  16  D-stage branch offset
//   imm26_d    in  26  D-stage jump index
//   rs_data_d  in  32  forwarded GPR[rs] for jr
//   instr_d    out 32  instruction in D
//   pc_d       out 32  address of instruction in D
//   pc8_d      out 32  pc_d + 8 (jal link value)
//   redirect   out  1  next PC is not pc_f + 4 (or a slot is being nullified);
//                      meaningless while stall = 1
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_f,
    output logic [31:0] pc_f,
    input  logic        cmp_out,
    input  logic [2:0]  npc_op,
    input  logic [15:0] imm16_d,
    input  logic [25:0] imm26_d,
    input  logic [31:0] rs_data_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        redirect
);

    localparam logic [2:0] OP_BR = 3'b001;
    localparam logic [2:0] OP_J  = 3'b010;
    localparam logic [2:0] OP_JR = 3'b011;
`ifdef BRANCH_LIKELY_EN
    localparam logic [2:0] OP_BL = 3'b100;
`endif

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;

    logic [31:0] w_seq;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_npc;
    logic        w_nullify;

    assign w_seq     = r_pc_f + 32'd4;
    // Branch and jump targets are relative to the branch/jump itself (in D),
    // not to the delay slot currently being fetched.
    assign w_br_tgt  = r_pc_d + 32'd4 + {{14{imm16_d[15]}}, imm16_d, 2'b00};
    assign w_jmp_tgt = {r_pc_d[31:28], imm26_d, 2'b00};

    always_comb begin
        w_npc     = w_seq;
        w_nullify = 1'b0;
        case (npc_op)
            OP_BR:   if (cmp_out) w_npc = w_br_tgt;
            OP_J:    w_npc = w_jmp_tgt;
            OP_JR:   w_npc = rs_data_d;
`ifdef BRANCH_LIKELY_EN
            OP_BL: begin
                if (cmp_out) w_npc     = w_br_tgt;
                else         w_nullify = 1'b1;
            end
`endif
            default: w_npc = w_seq;
        endcase
    end

    // A nullified slot keeps sequential fetch but still counts as a redirect.
    assign redirect = (w_npc != w_seq) | w_nullify;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc_f    <= PC_RESET;
            r_instr_d <= 32'd0;
            r_pc_d    <= 32'd0;
        end else if (!stall) begin
            r_pc_f    <= w_npc;
            r_instr_d <= w_nullify ? 32'd0 : instr_f;
            r_pc_d    <= r_pc_f;
        end
    end

    assign pc_f    = r_pc_f;
    assign instr_d = r_instr_d;
    assign pc_d    = r_pc_d;
    assign pc8_d   = r_pc_d + 32'd8;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr_f = 32'd0;
    logic [31:0] pc_f;
    logic        cmp_out = 1'b0;
    logic [2:0]  npc_op = 3'd0;
    logic [15:0] imm16_d = 16'd0;
    logic [25:0] imm26_d = 26'd0;
    logic [31:0] rs_data_d = 32'd0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        redirect;

    fetch_pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .instr_f(instr_f), .pc_f(pc_f),
        .cmp_out(cmp_out), .npc_op(npc_op), .imm16_d(imm16_d), .imm26_d(imm26_d),
        .rs_data_d(rs_data_d), .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d),
        .redirect(redirect)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        redirect;
        logic [31:0] pc_f;
        logic [31:0] instr_d;
        logic [31:0] pc_d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // Reference state: what the F and D stages hold, as seen by the program.
    logic [31:0] m_pc_f, m_pc_d, m_instr_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of D-stage control at the negedge and queue the
    // expected combinational redirect and post-edge register contents.
    task automatic issue(input logic [2:0] op, input logic cmp, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rs, input logic st,
                         input logic [31:0] ins);
        exp_t        e;
        logic [31:0] seq, npc;
        logic        nul;
        int          off;
        @(negedge clk);
        npc_op = op; cmp_out = cmp; imm16_d = i16; imm26_d = i26;
        rs_data_d = rs; stall = st; instr_f = ins;
        seq = m_pc_f + 32'd4;
        npc = seq;
        nul = 1'b0;
        off = $signed(i16);
        case (op)
            3'd1: if (cmp) npc = m_pc_d + 32'd4 + 32'(off * 4);
            3'd2: npc = (m_pc_d & 32'hF000_0000) + ({6'd0, i26} * 32'd4);
            3'd3: npc = rs;
`ifdef BRANCH_LIKELY_EN
            3'd4: if (cmp) npc = m_pc_d + 32'd4 + 32'(off * 4); else nul = 1'b1;
`endif
            default: npc = seq;
        endcase
        e.redirect = (npc != seq) || nul;
        if (!st) begin
            m_pc_d    = m_pc_f;
            m_instr_d = nul ? 32'd0 : ins;
            m_pc_f    = npc;
        end
        e.pc_f = m_pc_f; e.instr_d = m_instr_d; e.pc_d = m_pc_d;
        exp_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic seq_n(input int n);
        for (int i = 0; i < n; i++) issue(3'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0, $urandom);
    endtask

    // Asynchronous reset applied between edges; optionally while a taken
    // branch is being presented, which must be discarded.
    task automatic reset_dut(input logic mid_branch);
        @(negedge clk);
        stall = 1'b0; npc_op = mid_branch ? 3'd1 : 3'd0; cmp_out = mid_branch;
        imm16_d = 16'h0040;
        #3 reset = 1'b1;
        #1;
        chk("rst_pc_f", pc_f, 32'h0000_3000);
        chk("rst_instr_d", instr_d, 32'd0);
        chk("rst_pc_d", pc_d, 32'd0);
        chk("rst_pc8_d", pc8_d, 32'd8);
        npc_op = 3'd0; cmp_out = 1'b0;
        #1 chk("rst_redirect", {31'd0, redirect}, 32'd0);
        m_pc_f = 32'h0000_3000; m_pc_d = 32'd0; m_instr_d = 32'd0;
        settle();
        chk("rst_hold_pc_f", pc_f, 32'h0000_3000);
        reset = 1'b0;
    endtask

    // Monitor: pops one expectation per issued cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_redirect", {31'd0, redirect}, {31'd0, e.redirect});
                @(posedge clk);
                #1;
                chk("sb_pc_f", pc_f, e.pc_f);
                chk("sb_instr_d", instr_d, e.instr_d);
                chk("sb_pc_d", pc_d, e.pc_d);
                chk("sb_pc8_d", pc8_d, e.pc_d + 32'd8);
            end
        end
    end

    initial begin
        logic [31:0] w;
        m_pc_f = 32'd0; m_pc_d = 32'd0; m_instr_d = 32'd0;

        // Reset and sequential fetch
        reset_dut(1'b0);
        seq_n(3); settle();
        chk("seq_pc_f", pc_f, 32'h0000_300C);
        chk("seq_pc_d", pc_d, 32'h0000_3008);

        // Taken branch back to 0x3004; delay slot enters D
        seq_n(2);
        w = $urandom;
        issue(3'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0, 1'b0, w);
        #1 chk("tk_redirect", {31'd0, redirect}, 32'd1);
        settle();
        chk("tk_pc_f", pc_f, 32'h0000_3004);
        chk("tk_slot", instr_d, w);

        // Not-taken branch after a reset that interrupted a branch
        reset_dut(1'b1);
        seq_n(5);
        issue(3'd1, 1'b0, 16'hFFFC, 26'd0, 32'd0, 1'b0, $urandom);
        #1 chk("nt_redirect", {31'd0, redirect}, 32'd0);
        settle();
        chk("nt_pc_f", pc_f, 32'h0000_3018);

        // j and jr
        reset_dut(1'b0);
        seq_n(9);
        issue(3'd2, 1'b0, 16'd0, 26'h0000C40, 32'd0, 1'b0, $urandom);
        #1 chk("j_pc8_d", pc8_d, 32'h0000_3028);
        settle();
        chk("j_pc_f", pc_f, 32'h0000_3100);
        issue(3'd3, 1'b0, 16'd0, 26'd0, 32'h0000_3ABC, 1'b0, $urandom);
        settle();
        chk("jr_pc_f", pc_f, 32'h0000_3ABC);

        // Stall holds everything; redirect lands on the first free edge
        reset_dut(1'b0);
        seq_n(5);
        for (int i = 0; i < 2; i++) begin
            issue(3'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0, 1'b1, $urandom);
            settle();
            chk("stall_pc_f", pc_f, 32'h0000_3014);
            chk("stall_pc_d", pc_d, 32'h0000_3010);
        end
        w = $urandom;
        issue(3'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0, 1'b0, w);
        settle();
        chk("unstall_pc_f", pc_f, 32'h0000_3004);
        chk("unstall_slot", instr_d, w);

        // Branch-likely, not taken
        reset_dut(1'b0);
        seq_n(5);
        w = $urandom | 32'h1;
        issue(3'd4, 1'b0, 16'hFFFC, 26'd0, 32'd0, 1'b0, w);
`ifdef BRANCH_LIKELY_EN
        #1 chk("bl_redirect", {31'd0, redirect}, 32'd1);
        settle();
        chk("bl_instr_d", instr_d, 32'd0);
`else
        #1 chk("bl_redirect", {31'd0, redirect}, 32'd0);
        settle();
        chk("bl_instr_d", instr_d, w);
`endif
        chk("bl_pc_f", pc_f, 32'h0000_3018);
        chk("bl_pc_d", pc_d, 32'h0000_3014);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_dut(1'b1);
            issue(3'($urandom_range(0, 7)), 1'($urandom), 16'($urandom), 26'($urandom),
                  $urandom, ($urandom_range(0, 3) == 0), $urandom);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        settle();
        settle();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- IF-stage PC register, next-PC selection and F/D pipeline register for the 5-stage MIPS core.
- Sits directly downstream of the D-stage branch comparator.
- Consumes the comparator's 1-bit result together with the D-stage decoded jump/branch control, then redirects fetch.
- Delayed-branch semantics: the instruction after a branch/jump (delay slot) always enters D, unless it is nullified by the optional feature.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset; first fetch address.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  hazard-unit stall; freezes PC and F/D register.
- instr_f  input  32  instruction word read from IM at pc_f.
- pc_f  output  32  current fetch address to IM.
- cmp_out  input  1  D-stage comparator result (1 = branch condition true).
- npc_op  input  3  D-stage next-PC select: 000 seq, 001 branch, 010 j/jal, 011 jr, 100 branch-likely (optional).
- imm16_d  input  16  D-stage branch offset field.
- imm26_d  input  26  D-stage jump index field.
- rs_data_d  input  32  forwarded GPR[rs] for jr.
- instr_d  output  32  F/D register: instruction in D.
- pc_d  output  32  F/D register: address of instruction in D.
- pc8_d  output  32  pc_d + 8; link value for jal.
- redirect  output  1  combinational; 1 when npc is not pc_f + 4.

Behaviour:
- Reset, asynchronous, takes effect immediately regardless of clk: pc_f = PC_RESET, instr_d = 0 (nop), pc_d = 0.
- Derived outputs during reset: pc8_d = 8; redirect = 0, since instr_d is a nop and npc_op from the decoder is 000.
- npc is combinational:
  - 000: pc_f + 4.
  - 001: cmp_out ? br_tgt : pc_f + 4.
  - 010: jmp_tgt.
  - 011: rs_data_d.
  - 100: see Optional Feature.
  - 101-111: treated as 000.
- br_tgt = pc_d + 4 + (sign_extend(imm16_d) << 2). 32-bit wrap-around, no overflow detection.
- jmp_tgt = {pc_d[31:28], imm26_d, 2'b00}; upper bits come from pc_d (the jump's own address).
- jr target is used unmodified; no alignment check or trap.
- redirect = (npc != pc_f + 4) decision, asserted even when stall = 1. Informational only; the consumer must ignore it while stall = 1.
- Rising clk with stall = 0: pc_f <= npc; instr_d <= instr_f; pc_d <= pc_f. Latency: a taken branch in D fetches its target on the cycle after the delay slot is fetched, i.e. zero extra bubbles.
- Rising clk with stall = 1: pc_f, instr_d and pc_d all hold. cmp_out/npc_op changes during the stall have no effect, because the decision is re-evaluated on the non-stalled edge.
- pc8_d = pc_d + 8, combinational, 32-bit wrap.
- Reset asserted mid-stall or mid-branch: reset wins; the pending redirect is discarded.
- The block itself is pure datapath plus three registers; the D-stage branch/delay-slot sequencing emerges from the F/D register and PC register together.

Optional Feature:
- Macro: BRANCH_LIKELY_EN.
- Defined, npc_op = 100 (branch-likely):
  - Taken: identical to 001.
  - Not taken: npc = pc_f + 4, and on the next non-stalled edge instr_d <= 0 (delay slot nullified) with pc_d <= pc_f.
  - redirect = 1 on not-taken as well, to signal the nullification.
- Undefined: npc_op = 100 behaves as 000; no nullification logic or extra mux is synthesised.

Test Plan:
- Reset: assert reset between clock edges -> pc_f = 0x00003000, instr_d = 0, pc_d = 0 immediately; deassert, run 3 unstalled cycles with npc_op = 000 -> pc_f = 0x300C, pc_d = 0x3008.
- Taken branch: pc_d = 0x3010, pc_f = 0x3014, npc_op = 001, cmp_out = 1, imm16_d = 0xFFFC -> redirect = 1, next pc_f = 0x3004; instr_d = delay-slot word fetched at 0x3014.
- Not-taken branch: same as above with cmp_out = 0 -> next pc_f = 0x3018, redirect = 0.
- Jumps:
  - j: pc_d = 0x3020, imm26_d = 0x0000C40 -> next pc_f = 0x00003100; pc8_d = 0x3028.
  - jr: rs_data_d = 0x0000_3ABC -> next pc_f = 0x3ABC.
- Stall: hold stall = 1 for 2 cycles with npc_op = 001, cmp_out = 1 -> pc_f, pc_d, instr_d unchanged; release -> redirect applied on the first unstalled edge.
- BRANCH_LIKELY_EN build: npc_op = 100, cmp_out = 0, pc_f = 0x3014 -> next pc_f = 0x3018, instr_d = 0, pc_d = 0x3014. Non-macro build: same stimulus -> instr_d = instr_f.
